// File: rtl/systolic_skew_feeder.sv
// Skews A columns / B rows into the diagonal wavefront of an NxN systolic grid, then drains with zeros.
// Latency: an accepted A[i][k]/B[k][i] appears on lane i 1+i cycles later; done_o 2N cycles after the last accept.
// Backpressure: in_ready_o is high only while streaming; bubbles inject zeros on every lane.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [N*DW-1:0] a_col_i,
  input  logic [N*DW-1:0] b_row_i,
  output logic [N*DW-1:0] left_o,
  output logic [N*DW-1:0] up_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  logic          accept;

  assign accept = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_STREAM;
          k_d     = '0;
        end
      end
      ST_STREAM: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (in_valid_i) begin
          k_d = k_q + 1'b1;
          if (k_q == KW'(N - 1)) begin
            state_d = ST_DRAIN;
            c_d     = '0;
          end
        end
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        // Last PE captured its final MAC on the previous edge.
        if (c_q == CW'(2 * N - 1)) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane i is an (i+1)-deep chain; identical depths on both edges keep A/B pairs aligned.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_stg [0:i];
    logic [DW-1:0] b_stg [0:i];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s <= i; s++) begin
          a_stg[s] <= '0;
          b_stg[s] <= '0;
        end
      end else begin
        a_stg[0] <= accept ? a_col_i[i*DW +: DW] : '0;
        b_stg[0] <= accept ? b_row_i[i*DW +: DW] : '0;
        for (int s = 1; s <= i; s++) begin
          a_stg[s] <= a_stg[s-1];
          b_stg[s] <= b_stg[s-1];
        end
      end
    end

    assign left_o[i*DW +: DW] = a_stg[i];
    assign up_o[i*DW +: DW]   = b_stg[i];
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for an N×N grid of `PE_unit` cells. It accepts matrix operands as one column of A plus one row of B per handshake. It re-times them into the diagonal skew the systolic grid needs, and drives the grid's west edge (`left_i` of column-0 PEs) and north edge (`up_i` of row-0 PEs). It then inserts zeros until every PE accumulator holds its final C[i][j], and signals completion.

## Interface
- `N`, 4, array dimension (lanes per edge), N ≥ 2
- `DW`, 32, operand width; matches `PE_unit` `up_i`/`left_i`
- `clk_i`  in  1  clock, all state updates on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  begin a matrix pass; sampled only in IDLE
- `in_valid_i`  in  1  `a_col_i`/`b_row_i` hold operand vector k
- `in_ready_o`  out  1  feeder accepts a vector this cycle
- `a_col_i`  in  N*DW  A[i][k] at bits [i*DW +: DW]
- `b_row_i`  in  N*DW  B[k][j] at bits [j*DW +: DW]
- `left_o`  out  N*DW  lane i to `left_i` of PE(i,0)
- `up_o`  out  N*DW  lane j to `up_i` of PE(0,j)
- `busy_o`  out  1  high in STREAM and DRAIN
- `done_o`  out  1  one-cycle pulse: all `res_o` in grid final

## Operation
- Decided: one clock; reset is synchronous and active-high.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE → STREAM when `start_i`=1. The vector counter k is cleared.
  - STREAM: `in_ready_o`=1. An accept is `in_valid_i & in_ready_o`, and each accept increments k. On the N-th accept, go to DRAIN and clear the drain counter c.
  - DRAIN: `in_ready_o`=0. c increments every cycle. When c = 2N−1, assert `done_o` and go to IDLE.
- Skew: lane i of each edge is a shift chain with i+1 registers. Stage 0 loads the lane's input element on an accept, or zero otherwise. This includes zeros on bubbles, in IDLE, and in DRAIN.
- Bubbles (`in_valid_i`=0 in STREAM) inject zero on every lane of both edges. The A/B pairing is preserved because both edges use identical delays.
- `start_i` outside IDLE is ignored. `in_valid_i` outside STREAM is ignored; no data is captured.
- Arithmetic: no arithmetic in this block. Operands pass through bit-exact. The grid's 64-bit `res_o` accumulates DW×DW products.
- The feeder does not clear PE accumulators. The grid wrapper resets the PEs before `start_i`.
- Reset: state=IDLE, k=0, c=0, every chain register=0. All outputs are 0: `left_o`, `up_o`, `busy_o`, `done_o`, `in_ready_o`.
- Reset mid-pass has priority over everything. All chains are zeroed, so no partial operand leaks into the grid after reset.

## Timing
- Accept at edge of cycle t puts A[i][k] on `left_o` lane i and B[k][i] on `up_o` lane i during cycle t+1+i. Each value is present for exactly one cycle.
- With registered PE forwarding, PE(i,j) sees both operands in cycle t+1+i+j.
- Last accept in cycle t_L: c=0 in cycle t_L+1, and `done_o`=1 in cycle t_L+2N. This is one cycle after PE(N−1,N−1) captures its last MAC.
- `busy_o` is high from the cycle after `start_i` through the `done_o` cycle inclusive.
- Minimum pass with no bubbles: start at cycle s, accepts in s+1..s+N, `done_o` at s+3N. The next `start_i` is honoured in cycle s+3N+1.
- `in_ready_o` is a pure function of state, with no dependence on `in_valid_i`.

## Test plan
- Reset: hold `rst_i`=1 for 2 cycles with random inputs driven → all outputs 0, `in_ready_o`=0, FSM in IDLE.
- Skew, N=4: start, then one accept with `a_col_i`={4,3,2,1} (lane 0 = 1) followed by zeros → `left_o` lane i equals i+1 in cycle t+1+i only, and is 0 in all other cycles. Same check on `up_o` with `b_row_i`.
- End-to-end, N=2, with a 2×2 PE grid: A=[[1,2],[3,4]], B=[[5,6],[7,8]], no bubbles → at `done_o`, PE `res_o` = 19, 22, 43, 50. `done_o` rises 4 cycles after the last accept.
- Bubbles: same as the end-to-end case, but with `in_valid_i`=0 for 3 cycles between the two vectors → identical results, and `done_o` is delayed by exactly 3 cycles.
- Start while busy: pulse `start_i` in STREAM and in DRAIN → no state change, k and c unaffected, exactly one `done_o` pulse.
- Mid-pass reset: assert `rst_i` after 1 of 4 accepts → the next cycle has all lanes 0 and IDLE. A following full pass with identity A and B=[1..16] yields C=B.
